// File: rtl/usb_pkt_decoder.sv
// USB packet-layer decoder: PID check, CRC5/CRC16 validation, token field extraction and CRC-stripped payload.
// Optional macro USB_PKT_ERR_COUNT_EN adds err_count_o, a saturating count of packets ending with pkt_ok_o low.
module usb_pkt_decoder #(
  parameter int MAX_PAYLOAD = 1023
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  input  logic        rx_active_i,
  input  logic        rx_error_i,
  output logic [3:0]  pid_o,
  output logic        pid_valid_o,
  output logic [6:0]  tok_addr_o,
  output logic [3:0]  tok_endp_o,
  output logic [10:0] tok_frame_o,
  output logic        tok_valid_o,
  output logic [7:0]  dout_o,
  output logic        dout_valid_o,
  output logic        pkt_end_o,
  output logic        pkt_ok_o
`ifdef USB_PKT_ERR_COUNT_EN
  ,
  output logic [7:0]  err_count_o
`endif
);

  localparam int CW = $clog2(MAX_PAYLOAD + 3);
  localparam logic [CW-1:0] DATA_LIMIT = CW'(MAX_PAYLOAD + 2);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PID   = 3'd1,
    S_TOKEN = 3'd2,
    S_DATA  = 3'd3,
    S_HSK   = 3'd4,
    S_DRAIN = 3'd5,
    S_END   = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    CLS_TOKEN = 2'd0,
    CLS_DATA  = 2'd1,
    CLS_HSK   = 2'd2,
    CLS_BAD   = 2'd3
  } pid_cls_e;

  function automatic pid_cls_e pid_class(input logic [3:0] p);
    pid_cls_e cls;
    case (p)
      4'h1, 4'h9, 4'hD, 4'h4, 4'h5: cls = CLS_TOKEN;
      4'h3, 4'hB, 4'h7, 4'hF:       cls = CLS_DATA;
      4'h2, 4'hA, 4'hE, 4'h6:       cls = CLS_HSK;
      default:                      cls = CLS_BAD;
    endcase
    return cls;
  endfunction

  // Bytes arrive LSB first on the wire, so bit 0 is shifted in first.
  function automatic logic [4:0] crc5_byte(input logic [4:0] c_in, input logic [7:0] d);
    logic [4:0] c;
    logic       fb;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      fb = d[i] ^ c[4];
      c  = {c[3:0], 1'b0} ^ (fb ? 5'h05 : 5'h00);
    end
    return c;
  endfunction

  function automatic logic [15:0] crc16_byte(input logic [15:0] c_in, input logic [7:0] d);
    logic [15:0] c;
    logic        fb;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      fb = d[i] ^ c[15];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
    end
    return c;
  endfunction

  state_e        state_q, state_d;
  logic          armed_q, armed_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    crc5_q, crc5_d;
  logic [15:0]   crc16_q, crc16_d;
  logic [7:0]    tb1_q, tb1_d;
  logic [2:0]    tok_hi_q, tok_hi_d;
  logic [7:0]    hold0_q, hold0_d;
  logic [7:0]    hold1_q, hold1_d;
  logic [3:0]    pid_q, pid_d;
  logic          pid_valid_q, pid_valid_d;
  logic [6:0]    tok_addr_q, tok_addr_d;
  logic [3:0]    tok_endp_q, tok_endp_d;
  logic [10:0]   tok_frame_q, tok_frame_d;
  logic          tok_valid_q, tok_valid_d;
  logic [7:0]    dout_q, dout_d;
  logic          dout_valid_q, dout_valid_d;
  logic          pkt_end_q, pkt_end_d;
  logic          pkt_ok_q, pkt_ok_d;
  logic          ok_s;

  // Verdict the packet would get if it ended in the current cycle.
  always_comb begin
    ok_s = 1'b0;
    case (state_q)
      S_TOKEN: ok_s = (cnt_q == CW'(2)) && (crc5_q == 5'b01100);
      S_DATA:  ok_s = (cnt_q >= CW'(2)) && (crc16_q == 16'h800D);
      S_HSK:   ok_s = 1'b1;
      default: ok_s = 1'b0;
    endcase
  end

  // Next-state, datapath and output strobe logic.
  always_comb begin
    state_d      = state_q;
    armed_d      = armed_q;
    cnt_d        = cnt_q;
    crc5_d       = crc5_q;
    crc16_d      = crc16_q;
    tb1_d        = tb1_q;
    tok_hi_d     = tok_hi_q;
    hold0_d      = hold0_q;
    hold1_d      = hold1_q;
    pid_d        = pid_q;
    pid_valid_d  = 1'b0;
    tok_addr_d   = tok_addr_q;
    tok_endp_d   = tok_endp_q;
    tok_frame_d  = tok_frame_q;
    tok_valid_d  = 1'b0;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    pkt_end_d    = 1'b0;
    pkt_ok_d     = 1'b0;

    // A packet may only start after rx_active has been seen low (e.g. not mid-packet after reset).
    if (!rx_active_i) begin
      armed_d = 1'b1;
    end else begin
      armed_d = armed_q;
    end

    case (state_q)
      S_IDLE: begin
        if (rx_active_i && armed_q) begin
          state_d = S_PID;
          armed_d = 1'b0;
          cnt_d   = {CW{1'b0}};
          crc5_d  = 5'h1F;
          crc16_d = 16'hFFFF;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PID, S_TOKEN, S_DATA, S_HSK, S_DRAIN: begin
        if (!rx_active_i) begin
          state_d   = S_END;
          pkt_end_d = 1'b1;
          pkt_ok_d  = ok_s && !rx_error_i;
          if ((state_q == S_TOKEN) && ok_s && !rx_error_i) begin
            tok_valid_d = 1'b1;
            tok_addr_d  = tb1_q[6:0];
            tok_endp_d  = {tok_hi_q, tb1_q[7]};
            tok_frame_d = {tok_hi_q, tb1_q};
          end else begin
            tok_valid_d = 1'b0;
          end
        end else if (rx_error_i) begin
          state_d = S_DRAIN;
        end else if (rx_valid_i) begin
          case (state_q)
            S_PID: begin
              if (rx_data_i[7:4] == ~rx_data_i[3:0]) begin
                pid_d       = rx_data_i[3:0];
                pid_valid_d = 1'b1;
                case (pid_class(rx_data_i[3:0]))
                  CLS_TOKEN: state_d = S_TOKEN;
                  CLS_DATA:  state_d = S_DATA;
                  CLS_HSK:   state_d = S_HSK;
                  default:   state_d = S_DRAIN;
                endcase
              end else begin
                state_d = S_DRAIN;
              end
            end
            S_TOKEN: begin
              if (cnt_q == CW'(2)) begin
                state_d = S_DRAIN;
              end else begin
                cnt_d  = cnt_q + CW'(1);
                crc5_d = crc5_byte(crc5_q, rx_data_i);
                if (cnt_q == {CW{1'b0}}) begin
                  tb1_d = rx_data_i;
                end else begin
                  tok_hi_d = rx_data_i[2:0];
                end
              end
            end
            S_DATA: begin
              if (cnt_q == DATA_LIMIT) begin
                state_d = S_DRAIN;
              end else begin
                cnt_d   = cnt_q + CW'(1);
                crc16_d = crc16_byte(crc16_q, rx_data_i);
                // Two-byte holding pipe: the last two bytes are the CRC and never leave it.
                if (cnt_q == {CW{1'b0}}) begin
                  hold0_d = rx_data_i;
                end else if (cnt_q == CW'(1)) begin
                  hold1_d = rx_data_i;
                end else begin
                  dout_d       = hold0_q;
                  dout_valid_d = 1'b1;
                  hold0_d      = hold1_q;
                  hold1_d      = rx_data_i;
                end
              end
            end
            S_HSK:   state_d = S_DRAIN;
            default: state_d = S_DRAIN;
          endcase
        end else begin
          state_d = state_q;
        end
      end
      S_END:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      armed_q      <= 1'b0;
      cnt_q        <= {CW{1'b0}};
      crc5_q       <= 5'h1F;
      crc16_q      <= 16'hFFFF;
      tb1_q        <= 8'h00;
      tok_hi_q     <= 3'b000;
      hold0_q      <= 8'h00;
      hold1_q      <= 8'h00;
      pid_q        <= 4'h0;
      pid_valid_q  <= 1'b0;
      tok_addr_q   <= 7'h00;
      tok_endp_q   <= 4'h0;
      tok_frame_q  <= 11'h000;
      tok_valid_q  <= 1'b0;
      dout_q       <= 8'h00;
      dout_valid_q <= 1'b0;
      pkt_end_q    <= 1'b0;
      pkt_ok_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      armed_q      <= armed_d;
      cnt_q        <= cnt_d;
      crc5_q       <= crc5_d;
      crc16_q      <= crc16_d;
      tb1_q        <= tb1_d;
      tok_hi_q     <= tok_hi_d;
      hold0_q      <= hold0_d;
      hold1_q      <= hold1_d;
      pid_q        <= pid_d;
      pid_valid_q  <= pid_valid_d;
      tok_addr_q   <= tok_addr_d;
      tok_endp_q   <= tok_endp_d;
      tok_frame_q  <= tok_frame_d;
      tok_valid_q  <= tok_valid_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      pkt_end_q    <= pkt_end_d;
      pkt_ok_q     <= pkt_ok_d;
    end
  end

  assign pid_o        = pid_q;
  assign pid_valid_o  = pid_valid_q;
  assign tok_addr_o   = tok_addr_q;
  assign tok_endp_o   = tok_endp_q;
  assign tok_frame_o  = tok_frame_q;
  assign tok_valid_o  = tok_valid_q;
  assign dout_o       = dout_q;
  assign dout_valid_o = dout_valid_q;
  assign pkt_end_o    = pkt_end_q;
  assign pkt_ok_o     = pkt_ok_q;

`ifdef USB_PKT_ERR_COUNT_EN
  logic [7:0] err_cnt_q;

  // Failed-packet counter, saturating at all-ones.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_cnt_q <= 8'h00;
    end else if (pkt_end_d && !pkt_ok_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'h01;
    end else begin
      err_cnt_q <= err_cnt_q;
    end
  end

  assign err_count_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_usb_pkt_decoder.sv
// Scoreboard bench for usb_pkt_decoder: a packet-level reference model queues expected events, a monitor pops them.
module tb_usb_pkt_decoder;
  localparam int MAXP = 16;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_active = 1'b0;
  logic        rx_error = 1'b0;
  logic [3:0]  pid;
  logic        pid_valid;
  logic [6:0]  tok_addr;
  logic [3:0]  tok_endp;
  logic [10:0] tok_frame;
  logic        tok_valid;
  logic [7:0]  dout;
  logic        dout_valid;
  logic        pkt_end;
  logic        pkt_ok;
`ifdef USB_PKT_ERR_COUNT_EN
  logic [7:0]  err_count;
`endif

  always #5 clk = ~clk;

  usb_pkt_decoder #(.MAX_PAYLOAD(MAXP)) dut (
    .clk_i(clk), .rst_ni(rst_n), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .rx_active_i(rx_active), .rx_error_i(rx_error), .pid_o(pid), .pid_valid_o(pid_valid),
    .tok_addr_o(tok_addr), .tok_endp_o(tok_endp), .tok_frame_o(tok_frame), .tok_valid_o(tok_valid),
    .dout_o(dout), .dout_valid_o(dout_valid), .pkt_end_o(pkt_end), .pkt_ok_o(pkt_ok)
`ifdef USB_PKT_ERR_COUNT_EN
    , .err_count_o(err_count)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  int exp_errs = 0;
  logic [3:0]  q_pid[$];
  logic [7:0]  q_dout[$];
  logic [21:0] q_tok[$];
  logic        q_end[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: DUT strobe with no expected event queued", name);
  endtask

  function automatic logic [7:0] pb(input logic [3:0] p);
    return {~p, p};
  endfunction

  function automatic logic [4:0] crc5_bits(input logic [15:0] bits, input int nbits);
    logic [4:0] c;
    logic       fb;
    c = 5'h1F;
    for (int k = 0; k < nbits; k++) begin
      fb = bits[k] ^ c[4];
      c  = {c[3:0], 1'b0} ^ (fb ? 5'h05 : 5'h00);
    end
    return c;
  endfunction

  function automatic logic [15:0] crc16_q(input bq_t b, input int first, input int last);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int i = first; i <= last; i++) begin
      for (int k = 0; k < 8; k++) begin
        fb = b[i][k] ^ c[15];
        c  = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
      end
    end
    return c;
  endfunction

  // Token: 11-bit field (frame, or {endp,addr}) then the complemented CRC5, MSB first on the wire.
  function automatic bq_t gen_token(input logic [3:0] p, input logic [10:0] f);
    bq_t        pk;
    logic [4:0] c;
    c = crc5_bits({5'b00000, f}, 11);
    pk.push_back(pb(p));
    pk.push_back(f[7:0]);
    pk.push_back({~c[0], ~c[1], ~c[2], ~c[3], ~c[4], f[10:8]});
    return pk;
  endfunction

  function automatic bq_t gen_data(input logic [3:0] p, input int len, input bit seq);
    bq_t         pk;
    bq_t         pay;
    logic [15:0] c;
    logic [7:0]  b0;
    logic [7:0]  b1;
    for (int i = 0; i < len; i++) pay.push_back(seq ? 8'(i) : 8'($urandom));
    c = crc16_q(pay, 0, len - 1);
    for (int i = 0; i < 8; i++) begin
      b0[i] = ~c[15 - i];
      b1[i] = ~c[7 - i];
    end
    pk.push_back(pb(p));
    foreach (pay[i]) pk.push_back(pay[i]);
    pk.push_back(b0);
    pk.push_back(b1);
    return pk;
  endfunction

  // Reference model: packet bytes plus rx_error position give the expected event stream.
  task automatic model(input bq_t pk, input int err_at);
    logic [3:0] p;
    int         n;
    bit         err;
    bit         ok;
    p   = pk[0][3:0];
    err = (err_at >= 0);
    n   = err ? err_at : pk.size() - 1;
    ok  = 1'b0;
    if (pk[0][7:4] == ~pk[0][3:0]) begin
      q_pid.push_back(p);
      case (p)
        4'h1, 4'h9, 4'hD, 4'h4, 4'h5: begin
          ok = !err && (n == 2) && (crc5_bits({pk[2], pk[1]}, 16) == 5'b01100);
          if (ok) q_tok.push_back({pk[1][6:0], pk[2][2:0], pk[1][7], pk[2][2:0], pk[1]});
        end
        4'h3, 4'hB, 4'h7, 4'hF: begin
          for (int i = 0; i < ((n < MAXP + 2) ? n : MAXP + 2) - 2; i++) q_dout.push_back(pk[1 + i]);
          ok = !err && (n >= 2) && (n <= MAXP + 2) && (crc16_q(pk, 1, n) == 16'h800D);
        end
        4'h2, 4'hA, 4'hE, 4'h6: ok = !err && (n == 0);
        default: ok = 1'b0;
      endcase
    end
    q_end.push_back(ok);
    if (!ok) exp_errs++;
  endtask

  task automatic send(input bq_t pk, input int err_at, input int tail_gap);
    rx_active = 1'b1;
    repeat (2) @(negedge clk);
    foreach (pk[i]) begin
      rx_data  = pk[i];
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      if (i == err_at) begin
        rx_error = 1'b1;
        @(negedge clk);
        rx_error = 1'b0;
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    rx_active = 1'b0;
    // A stray strobe while rx_active is low must be ignored.
    rx_valid = 1'b1;
    rx_data  = 8'($urandom);
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (tail_gap - 1) @(negedge clk);
  endtask

  task automatic run(input bq_t pk, input int err_at, input int tail_gap);
    model(pk, err_at);
    send(pk, err_at, tail_gap);
  endtask

  // Monitor: pops and compares on every DUT strobe.
  always @(negedge clk) begin
    if (rst_n) begin
      if (pid_valid) begin
        if (q_pid.size() == 0) unexpected("pid");
        else check("pid", 64'(pid), 64'(q_pid.pop_front()));
      end
      if (dout_valid) begin
        if (q_dout.size() == 0) unexpected("dout");
        else check("dout", 64'(dout), 64'(q_dout.pop_front()));
      end
      if (tok_valid) begin
        if (q_tok.size() == 0) unexpected("tok");
        else check("tok_fields", 64'({tok_addr, tok_endp, tok_frame}), 64'(q_tok.pop_front()));
      end
      if (pkt_end) begin
        if (q_end.size() == 0) unexpected("pkt_end");
        else check("pkt_ok", 64'(pkt_ok), 64'(q_end.pop_front()));
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t        pk;
    int         err_at;
    logic [3:0] tok_pids [5];
    logic [3:0] dat_pids [4];
    logic [3:0] hsk_pids [4];
    tok_pids = '{4'h1, 4'h9, 4'hD, 4'h4, 4'h5};
    dat_pids = '{4'h3, 4'hB, 4'h7, 4'hF};
    hsk_pids = '{4'h2, 4'hA, 4'hE, 4'h6};

    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({pid, pid_valid, tok_addr, tok_endp, tok_frame, tok_valid,
                                dout, dout_valid, pkt_end, pkt_ok}), 64'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    pk = '{8'hD2};                       run(pk, -1, 3);
    pk = gen_data(4'h3, 0, 1'b1);        run(pk, -1, 3);
    pk = gen_data(4'hB, 8, 1'b1);        run(pk, -1, 2);
    pk = gen_token(4'hD, {4'hE, 7'h15}); run(pk, -1, 1);
    pk[2] = pk[2] ^ 8'h08;               run(pk, -1, 3);
    pk = '{8'h2E, 8'h00, 8'h00};         run(pk, -1, 1);
    pk = '{8'hD2};                       run(pk, -1, 3);
    pk = gen_data(4'h3, 8, 1'b0);        run(pk, 4, 3);
    pk = gen_data(4'h7, MAXP, 1'b0);     run(pk, -1, 2);
    pk = gen_data(4'hF, MAXP + 1, 1'b0); run(pk, -1, 2);
    pk = '{8'hC3, 8'h00};                run(pk, -1, 2);
    pk = '{8'hD2, 8'h00};                run(pk, -1, 2);
    pk = gen_token(4'h1, 11'h2A5);
    pk.push_back(8'h55);                 run(pk, -1, 2);

    // Reset in the middle of a DATA payload; the rest of that packet must be ignored.
    pk = gen_data(4'h3, 6, 1'b0);
    q_pid.push_back(4'h3);
    q_dout.push_back(pk[1]);
    q_dout.push_back(pk[2]);
    rx_active = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      rx_data  = pk[i];
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("reset_mid_outputs", 64'({pid, pid_valid, tok_addr, tok_endp, tok_frame, tok_valid,
                                    dout, dout_valid, pkt_end, pkt_ok}), 64'd0);
    rst_n = 1'b1;
    exp_errs = 0;
    for (int i = 5; i < pk.size(); i++) begin
      rx_data  = pk[i];
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
    end
    rx_active = 1'b0;
    repeat (3) @(negedge clk);
    pk = gen_token(4'h5, 11'h7FF);       run(pk, -1, 3);

    for (int t = 0; t < 60; t++) begin
      err_at = -1;
      case ($urandom_range(0, 6))
        0: pk = gen_token(tok_pids[$urandom_range(0, 4)], 11'($urandom));
        1: begin
          pk = gen_token(tok_pids[$urandom_range(0, 4)], 11'($urandom));
          pk[$urandom_range(1, 2)] ^= (8'h01 << $urandom_range(0, 7));
        end
        2: pk = gen_data(dat_pids[$urandom_range(0, 3)], $urandom_range(0, MAXP), 1'b0);
        3: begin
          pk = gen_data(dat_pids[$urandom_range(0, 3)], $urandom_range(0, MAXP), 1'b0);
          pk[$urandom_range(1, pk.size() - 1)] ^= (8'h01 << $urandom_range(0, 7));
        end
        4: pk = '{pb(hsk_pids[$urandom_range(0, 3)])};
        5: begin
          pk = gen_data(dat_pids[$urandom_range(0, 3)], $urandom_range(3, MAXP), 1'b0);
          err_at = $urandom_range(1, pk.size() - 1);
        end
        default: pk = gen_data(dat_pids[$urandom_range(0, 3)], MAXP + $urandom_range(1, 3), 1'b0);
      endcase
      run(pk, err_at, $urandom_range(1, 4));
    end

    repeat (10) @(negedge clk);
    check("pid_leftover", 64'(q_pid.size()), 64'd0);
    check("dout_leftover", 64'(q_dout.size()), 64'd0);
    check("tok_leftover", 64'(q_tok.size()), 64'd0);
    check("end_leftover", 64'(q_end.size()), 64'd0);
`ifdef USB_PKT_ERR_COUNT_EN
    check("err_count", 64'(err_count), 64'((exp_errs > 255) ? 255 : exp_errs));
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
